// File: rtl/rs_pkg.sv
// Shared definitions for the age-ordered ALU reservation station.
// Holds default sizing, the "operand ready" tag value and the
// default-width entry record used by software-side models.
package rs_pkg;

    localparam int RS_DEPTH = 16;
    localparam int RS_TAG_W = 5;
    localparam int RS_NCDB  = 2;
    localparam int RS_XLEN  = 32;
    localparam int RS_OP_W  = 7;

    // ROB ids are 1-based, so tag 0 means "value already present".
    localparam logic [RS_TAG_W-1:0] TAG_READY = '0;

    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  op;
        logic [RS_XLEN-1:0]  pc;
        logic [RS_XLEN-1:0]  imm;
        logic [RS_XLEN-1:0]  vi;
        logic [RS_XLEN-1:0]  vj;
        logic [RS_TAG_W-1:0] qi;
        logic [RS_TAG_W-1:0] qj;
        logic [RS_TAG_W-1:0] rd;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_issue_queue_if.sv
// Bundle between dispatcher/CDB/ALU and the reservation station.
// master: the environment (dispatcher, CDB, ALU, ROB control).
// slave : the reservation station itself.
interface rs_age_issue_queue_if
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int TAG_W = RS_TAG_W,
    parameter int NCDB  = RS_NCDB,
    parameter int XLEN  = RS_XLEN,
    parameter int OP_W  = RS_OP_W
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  rdy;
    logic                  flush;
    logic                  disp_valid;
    logic [OP_W-1:0]       disp_op;
    logic [XLEN-1:0]       disp_pc;
    logic [XLEN-1:0]       disp_imm;
    logic [XLEN-1:0]       disp_vi;
    logic [XLEN-1:0]       disp_vj;
    logic [TAG_W-1:0]      disp_qi;
    logic [TAG_W-1:0]      disp_qj;
    logic [TAG_W-1:0]      disp_rd;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0]  cdb_data;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [OP_W-1:0]       iss_op;
    logic [XLEN-1:0]       iss_vi;
    logic [XLEN-1:0]       iss_vj;
    logic [XLEN-1:0]       iss_imm;
    logic [XLEN-1:0]       iss_pc;
    logic [TAG_W-1:0]      iss_rd;

    modport master (
        output rdy, flush, disp_valid, disp_op, disp_pc, disp_imm,
               disp_vi, disp_vj, disp_qi, disp_qj, disp_rd,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  full, count, iss_valid, iss_op, iss_vi, iss_vj,
               iss_imm, iss_pc, iss_rd
    );

    modport slave (
        input  rdy, flush, disp_valid, disp_op, disp_pc, disp_imm,
               disp_vi, disp_vj, disp_qi, disp_qj, disp_rd,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output full, count, iss_valid, iss_op, iss_vi, iss_vj,
               iss_imm, iss_pc, iss_rd
    );
endinterface

// File: rtl/rs_age_select.sv
// Oldest-ready picker. age[i][j]=1 means entry i is older than entry j.
// Ports: ready (per-entry request), age (matrix) -> grant (one-hot),
// any_ready. Purely combinational.
module rs_age_select
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        any_ready
);
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
        logic [DEPTH-1:0] older_ready;
        // Entry gi wins only if no ready entry is older than it.
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_row
            assign older_ready[gj] = ready[gj] & age[gj][gi];
        end
        assign grant[gi] = ready[gi] & ~(|older_ready);
    end

    assign any_ready = |ready;
endmodule

// File: rtl/rs_age_issue_queue.sv
// Age-ordered ALU reservation station with a registered issue slot.
// Ports: clk, rst (sync, active-high), bus (slave side of
// rs_age_issue_queue_if: dispatch, CDB snoop, issue handshake, rdy/flush,
// full/count status).
module rs_age_issue_queue
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int TAG_W = RS_TAG_W,
    parameter int NCDB  = RS_NCDB,
    parameter int XLEN  = RS_XLEN,
    parameter int OP_W  = RS_OP_W
) (
    input  logic                clk,
    input  logic                rst,
    rs_age_issue_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_READY);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  vi;
        logic [XLEN-1:0]  vj;
        logic [TAG_W-1:0] qi;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] rd;
    } slot_t;

    // Returns {hit, data}; scanning from the top lets the lowest channel win.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]      tag,
        input logic [NCDB-1:0]       vld,
        input logic [NCDB*TAG_W-1:0] tags,
        input logic [NCDB*XLEN-1:0]  data
    );
        logic [XLEN:0] r;
        r = '0;
        if (tag != TAG_ZERO) begin
            for (int c = NCDB - 1; c >= 0; c--) begin
                if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) begin
                    r = {1'b1, data[c*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    slot_t                       slot_q [DEPTH];
    slot_t                       slot_d [DEPTH];
    logic                        iss_valid_q, iss_valid_d;
    slot_t                       iss_q, iss_d;

    logic [DEPTH-1:0] ready, grant;
    logic             any_ready;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic [XLEN:0]    wk_i [DEPTH];
    logic [XLEN:0]    wk_j [DEPTH];
    logic [XLEN:0]    byp_i, byp_j;
    slot_t            new_slot;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign ready[gi] = busy_q[gi] && slot_q[gi].qi == TAG_ZERO
                                      && slot_q[gi].qj == TAG_ZERO;
        assign wk_i[gi]  = cdb_lookup(slot_q[gi].qi, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        assign wk_j[gi]  = cdb_lookup(slot_q[gi].qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    rs_age_select #(.DEPTH(DEPTH)) u_select (
        .ready     (ready),
        .age       (age_q),
        .grant     (grant),
        .any_ready (any_ready)
    );

    always_comb begin
        count    = '0;
        free_idx = '0;
        sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(busy_q[i]);
            if (grant[i]) sel_idx = sel_idx | IDX_W'(i);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign full = &busy_q;

    // Dispatched operands may be satisfied by a broadcast in the same cycle.
    always_comb begin
        byp_i       = cdb_lookup(bus.disp_qi, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp_j       = cdb_lookup(bus.disp_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        new_slot.op  = bus.disp_op;
        new_slot.pc  = bus.disp_pc;
        new_slot.imm = bus.disp_imm;
        new_slot.rd  = bus.disp_rd;
        new_slot.vi  = byp_i[XLEN] ? byp_i[XLEN-1:0] : bus.disp_vi;
        new_slot.vj  = byp_j[XLEN] ? byp_j[XLEN-1:0] : bus.disp_vj;
        new_slot.qi  = byp_i[XLEN] ? TAG_ZERO : bus.disp_qi;
        new_slot.qj  = byp_j[XLEN] ? TAG_ZERO : bus.disp_qj;
    end

    always_comb begin
        busy_d      = busy_q;
        age_d       = age_q;
        slot_d      = slot_q;
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        if (bus.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && wk_i[i][XLEN]) begin
                    slot_d[i].vi = wk_i[i][XLEN-1:0];
                    slot_d[i].qi = TAG_ZERO;
                end
                if (busy_q[i] && wk_j[i][XLEN]) begin
                    slot_d[i].vj = wk_j[i][XLEN-1:0];
                    slot_d[i].qj = TAG_ZERO;
                end
            end
            if (!iss_valid_q || bus.iss_ready) begin
                if (any_ready) begin
                    iss_d           = slot_q[sel_idx];
                    iss_valid_d     = 1'b1;
                    busy_d[sel_idx] = 1'b0;
                end else begin
                    iss_valid_d = 1'b0;
                end
            end
            // full is from pre-edge busy, so a slot freed by issue is not reused now.
            if (bus.disp_valid && !full) begin
                busy_d[free_idx] = 1'b1;
                slot_d[free_idx] = new_slot;
                age_d[free_idx]  = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (busy_q[j]) age_d[j][free_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (bus.rdy && bus.flush)) begin
            busy_q      <= '0;
            age_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            age_q       <= age_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end

    // Payload storage needs no reset: busy gates every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

    assign bus.full      = full;
    assign bus.count     = count;
    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_op    = iss_q.op;
    assign bus.iss_pc    = iss_q.pc;
    assign bus.iss_imm   = iss_q.imm;
    assign bus.iss_vi    = iss_q.vi;
    assign bus.iss_vj    = iss_q.vj;
    assign bus.iss_rd    = iss_q.rd;
endmodule

// File: tb/tb_rs_age_issue_queue.sv
module tb_rs_age_issue_queue;
    import rs_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAG_W = 5;
    localparam int NCDB  = 2;
    localparam int XLEN  = 32;
    localparam int OP_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs_age_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB),
                            .XLEN(XLEN), .OP_W(OP_W)) bus ();

    rs_age_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB),
                         .XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: dispatch-ordered list of waiting instructions
    // plus the contents of the issue slot.
    rs_entry_t mq[$];
    rs_entry_t m_iss;
    bit        m_valid;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void lookup(input logic [TAG_W-1:0] tag, output bit hit,
                                   output logic [XLEN-1:0] d);
        hit = 0;
        d   = '0;
        if (tag != 0) begin
            for (int c = 0; c < NCDB; c++) begin
                if (!hit && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == tag) begin
                    hit = 1;
                    d   = bus.cdb_data[c*XLEN +: XLEN];
                end
            end
        end
    endfunction

    task automatic model_edge();
        bit              hit;
        logic [XLEN-1:0] d;
        int              sel;
        bit              was_full;
        rs_entry_t       e;
        if (rst || (bus.rdy && bus.flush)) begin
            mq.delete();
            m_valid = 0;
            m_iss   = '0;
            return;
        end
        if (!bus.rdy) return;
        was_full = (mq.size() == DEPTH);
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].qi == 0 && mq[i].qj == 0) begin
                sel = i;
                break;
            end
        end
        if (!m_valid || bus.iss_ready) begin
            if (sel >= 0) begin
                m_iss   = mq[sel];
                m_valid = 1;
                mq.delete(sel);
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            lookup(mq[i].qi, hit, d);
            if (hit) begin mq[i].vi = d; mq[i].qi = 0; end
            lookup(mq[i].qj, hit, d);
            if (hit) begin mq[i].vj = d; mq[i].qj = 0; end
        end
        if (bus.disp_valid && !was_full) begin
            e      = '0;
            e.busy = 1;
            e.op   = bus.disp_op;
            e.pc   = bus.disp_pc;
            e.imm  = bus.disp_imm;
            e.rd   = bus.disp_rd;
            e.vi   = bus.disp_vi;
            e.vj   = bus.disp_vj;
            e.qi   = bus.disp_qi;
            e.qj   = bus.disp_qj;
            lookup(e.qi, hit, d);
            if (hit) begin e.vi = d; e.qi = 0; end
            lookup(e.qj, hit, d);
            if (hit) begin e.vj = d; e.qj = 0; end
            mq.push_back(e);
        end
    endtask

    task automatic compare();
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("iss_valid", 32'(bus.iss_valid), 32'(m_valid));
        if (m_valid) begin
            chk("iss_op", 32'(bus.iss_op), 32'(m_iss.op));
            chk("iss_pc", bus.iss_pc, m_iss.pc);
            chk("iss_imm", bus.iss_imm, m_iss.imm);
            chk("iss_vi", bus.iss_vi, m_iss.vi);
            chk("iss_vj", bus.iss_vj, m_iss.vj);
            chk("iss_rd", 32'(bus.iss_rd), 32'(m_iss.rd));
            if (bus.iss_ready)
                $display("issue cycle=%0d rd=%0d vi=%h vj=%h", cyc, m_iss.rd, m_iss.vi, m_iss.vj);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare();
    endtask

    task automatic idle();
        bus.disp_valid = 0;
        bus.disp_op    = '0;
        bus.disp_pc    = '0;
        bus.disp_imm   = '0;
        bus.disp_vi    = '0;
        bus.disp_vj    = '0;
        bus.disp_qi    = '0;
        bus.disp_qj    = '0;
        bus.disp_rd    = '0;
        bus.cdb_valid  = '0;
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vi,
                        input logic [XLEN-1:0] vj, input logic [TAG_W-1:0] qi,
                        input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] rd);
        bus.disp_valid = 1;
        bus.disp_op    = op;
        bus.disp_pc    = 32'h1000 + 32'(rd) * 4;
        bus.disp_imm   = 32'(rd) << 8;
        bus.disp_vi    = vi;
        bus.disp_vj    = vj;
        bus.disp_qi    = qi;
        bus.disp_qj    = qj;
        bus.disp_rd    = rd;
    endtask

    task automatic cdb(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        bus.cdb_valid[ch]              = 1;
        bus.cdb_tag[ch*TAG_W +: TAG_W] = tag;
        bus.cdb_data[ch*XLEN +: XLEN]  = data;
    endtask

    initial begin
        idle();
        bus.rdy       = 1;
        bus.flush     = 0;
        bus.iss_ready = 1;
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst_iss_op", 32'(bus.iss_op), 32'h0);
        chk("rst_iss_vi", bus.iss_vi, 32'h0);
        chk("rst_iss_pc", bus.iss_pc, 32'h0);
        chk("rst_iss_rd", 32'(bus.iss_rd), 32'h0);

        // Single ready ADD: visible two edges after dispatch.
        disp(7'h33, 32'd3, 32'd4, 0, 0, 5'd5); step();
        idle(); step();
        chk("lat_iss_valid", 32'(bus.iss_valid), 32'h1);
        chk("lat_iss_rd", 32'(bus.iss_rd), 32'd5);
        repeat (3) step();
        chk("lat_count", 32'(bus.count), 32'h0);

        // A waits on tag 7, B and C ready; wakeup then issues A last.
        disp(7'h01, 0, 32'd11, 5'd7, 0, 5'd1); step();
        disp(7'h02, 32'd21, 32'd22, 0, 0, 5'd2); step();
        disp(7'h03, 32'd31, 32'd32, 0, 0, 5'd3); step();
        idle(); cdb(0, 5'd7, 32'h10); step();
        idle(); repeat (5) step();

        // Older A lands in a higher index than younger B.
        bus.iss_ready = 0;
        disp(7'h04, 32'd1, 32'd1, 0, 0, 5'd8); step();
        disp(7'h05, 32'd2, 32'd2, 0, 0, 5'd9); step();
        disp(7'h06, 32'd3, 32'd3, 0, 0, 5'd10); step();
        idle(); step(); step();
        bus.iss_ready = 1;
        repeat (5) step();

        // Same-cycle bypass on channel 1.
        disp(7'h07, 32'd5, 32'd0, 0, 5'd9, 5'd11);
        cdb(1, 5'd9, 32'hAB); step();
        idle(); step();
        chk("byp_iss_vj", bus.iss_vj, 32'hAB);
        repeat (2) step();

        // Fill past capacity with the ALU stalled.
        bus.iss_ready = 0;
        for (int i = 0; i < 19; i++) begin
            disp(7'h10, 32'(i), 32'(i + 100), 0, 0, 5'(i + 1)); step();
        end
        idle();
        chk("fill_full", 32'(bus.full), 32'h1);
        chk("fill_count", 32'(bus.count), 32'd16);
        repeat (10) step();
        bus.iss_ready = 1;
        repeat (20) step();

        // Flush with six waiting entries and an occupied issue slot.
        bus.iss_ready = 0;
        disp(7'h20, 32'd1, 32'd2, 0, 0, 5'd12); step();
        for (int i = 0; i < 6; i++) begin
            disp(7'h21, 0, 32'd7, 5'd3, 0, 5'(13 + i)); step();
        end
        idle(); step();
        bus.flush = 1; step();
        bus.flush = 0;
        chk("flush_count", 32'(bus.count), 32'h0);
        chk("flush_iss_valid", 32'(bus.iss_valid), 32'h0);
        chk("flush_full", 32'(bus.full), 32'h0);
        cdb(0, 5'd3, 32'h55); step();
        idle(); bus.iss_ready = 1; repeat (3) step();

        // Freeze with rdy low while inputs toggle.
        disp(7'h30, 0, 32'd1, 5'd4, 0, 5'd20); step();
        disp(7'h31, 32'd2, 32'd3, 0, 0, 5'd21); step();
        bus.rdy = 0;
        for (int i = 0; i < 3; i++) begin
            disp(7'h32, 32'(i), 32'(i), 0, 0, 5'(22 + i));
            cdb(i % 2, 5'd4, 32'h77 + 32'(i));
            step();
        end
        bus.rdy = 1;
        idle(); cdb(0, 5'd4, 32'h99); step();
        idle(); repeat (4) step();

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(2) != 0) begin
                disp(7'($urandom), $urandom, $urandom,
                     ($urandom_range(3) == 0) ? 5'($urandom_range(7, 1)) : 5'd0,
                     ($urandom_range(3) == 0) ? 5'($urandom_range(7, 1)) : 5'd0,
                     5'($urandom_range(31, 1)));
            end
            for (int c = 0; c < NCDB; c++) begin
                if ($urandom_range(1) != 0) cdb(c, 5'($urandom_range(7)), $urandom);
            end
            bus.iss_ready = ($urandom_range(3) != 0);
            bus.rdy       = ($urandom_range(9) != 0);
            bus.flush     = bus.rdy && ($urandom_range(99) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rs_age_issue_queue.md
Name: rs_age_issue_queue

Overview:
- Parametrised successor of the ALU reservation station: DEPTH entries, NCDB result-broadcast channels, oldest-ready-first selection.
- Issue output is a registered valid/ready handshake toward the ALU, so a stalled ALU does not lose or duplicate instructions.
- Sits between dispatcher and ALU; snoops all CDB channels (ALU, LSB, and future units); cleared by ROB mispredict flush.

Parameters:
- DEPTH, 16, number of entries (power of two, >=2)
- TAG_W, 5, ROB tag width; tag 0 = "operand ready", ROB ids are 1-based
- NCDB, 2, number of broadcast channels
- XLEN, 32, data width
- OP_W, 7, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  ROB wrong-commit; clears queue
- disp_valid  in  1  dispatch request
- disp_op  in  OP_W  opcode
- disp_pc  in  XLEN  instruction pc
- disp_imm  in  XLEN  immediate
- disp_vi, disp_vj  in  XLEN  operand values
- disp_qi, disp_qj  in  TAG_W  operand tags
- disp_rd  in  TAG_W  destination ROB tag
- full  out  1  no free entry (combinational from registered busy)
- count  out  $clog2(DEPTH)+1  occupied entries
- cdb_valid  in  NCDB  per-channel broadcast valid
- cdb_tag  in  NCDB*TAG_W  packed tags, channel 0 in LSBs
- cdb_data  in  NCDB*XLEN  packed results
- iss_valid  out  1  issue slot holds an instruction
- iss_ready  in  1  ALU accepts this cycle
- iss_op  out  OP_W  registered opcode
- iss_vi, iss_vj, iss_imm, iss_pc  out  XLEN  registered operands
- iss_rd  out  TAG_W  registered destination tag

Behaviour:
- Reset/flush (flush outranks dispatch, wakeup, issue): all busy=0, age matrix=0, iss_valid=0, all iss_* data=0, count=0; takes effect next edge. rdy=0: no state change; outputs hold.
- Dispatch: accepted when disp_valid && !full. Written to lowest-index free entry. Operands are captured with same-cycle bypass: if any valid CDB channel matches a nonzero disp_qi/disp_qj, store its data and tag 0. Lowest-index channel wins on duplicate tags. Dispatch while full is dropped; the dispatcher must not do this.
- Wakeup: for every busy entry and channel c, cdb_valid[c] && cdb_tag[c]!=0 && Q==cdb_tag[c] loads the data and clears Q. cdb_tag 0 is ignored.
- Age: DEPTH x DEPTH matrix, old[i][j]=1 means i older than j. On dispatch to entry k, row k is cleared and column k is set for all busy entries.
- Ready: busy && qi==0 && qj==0, using registered values. An entry woken or dispatched in cycle N is selectable in cycle N+1 at earliest (one-cycle wakeup-to-select).
- Select: the oldest ready entry (no ready entry older than it). Computed combinationally.
- Issue register load: when (!iss_valid || iss_ready) && a ready entry exists, the selected entry is copied to iss_*. It is freed (busy=0) on the same edge and iss_valid=1.
- Issue register drain: if (!iss_valid || iss_ready) and no ready entry exists, iss_valid=0. If iss_valid && !iss_ready, iss_* hold stable.
- Throughput: 1 issue/cycle; latency dispatch-with-ready-operands to iss_valid = 2 edges.
- A freed entry is not reusable for dispatch on the same edge (full uses pre-edge busy).
- count = popcount(busy) from registered state.
- Full occupancy: full=1 exactly when count==DEPTH.

Decomposition:
- Package rs_pkg: default DEPTH/TAG_W/XLEN/OP_W, TAG_READY=0 constant, entry struct {busy, op, pc, imm, vi, vj, qi, qj, rd}.
- Sub-module rs_age_select: takes ready vector and age matrix, returns one-hot grant plus any_ready. Purely combinational and separately testable.

Test Plan:
- Reset then dispatch op=ADD, qi=qj=0, vi=3, vj=4, rd=5 -> iss_valid=1 two edges later with vi=3, vj=4, rd=5; count returns to 0.
- Dispatch A (qi=7), then B (ready), then C (ready); CDB0 tag7 data 0x10 -> issue order B, C, then A with vi=0x10. Second case: A, B both ready -> A issues before B regardless of entry index.
- Dispatch with disp_qj=9 while cdb_valid[1]=1, cdb_tag[1]=9, cdb_data=0xAB in the same cycle -> entry stored with qj=0, vj=0xAB; issues without further broadcast.
- Fill 16 entries with iss_ready=0 -> full=1, count=16, iss_* stable for 10 cycles; a 17th dispatch is dropped. Then iss_ready=1 -> one issue per cycle, each exactly once, oldest first.
- Mid-operation flush with 6 busy entries and iss_valid=1 -> next edge iss_valid=0, count=0, full=0; a later CDB with an old tag has no effect.
- rdy=0 for 3 cycles while CDB and dispatch toggle -> no state change; behaviour resumes identically when rdy=1.
